// File: rtl/round_tracker_if.sv
// Signal bundle between the game FSM and the round tracker: the player's guess,
// the round's target and difficulty settings in, score and timer status out.
interface round_tracker_if;
  logic       confirmButton;
  logic [9:0] guess;
  logic [9:0] target;
  logic [1:0] Max_digit;
  logic [2:0] Max_incorrect_guesses;
  logic [2:0] incorrect_guesses;
  logic [2:0] round;
  logic [6:0] timer;
  logic       correct;
  logic       new_target;
  logic       locked_out;

  modport master (
    output confirmButton, guess, target, Max_digit, Max_incorrect_guesses,
    input  incorrect_guesses, round, timer, correct, new_target, locked_out
  );

  modport slave (
    input  confirmButton, guess, target, Max_digit, Max_incorrect_guesses,
    output incorrect_guesses, round, timer, correct, new_target, locked_out
  );
endinterface

// File: rtl/round_tracker.sv
// Round tracker: counts correct and wrong guesses for the current difficulty
// level and runs a per-level countdown timer in whole seconds. A change of
// difficulty level restarts the bookkeeping through a one-cycle LOAD state.
module round_tracker #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned ROUND_SECONDS = 30
) (
  input logic            clk,
  input logic            restart,
  round_tracker_if.slave bus
);

  localparam int unsigned       PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [6:0]        SECONDS    = 7'(ROUND_SECONDS);

  typedef enum logic [1:0] {LOAD, PLAY, HOLD} state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         level_reg;
  logic [PRESC_W-1:0] prescaler;
  logic               confirm_prev;
  logic [2:0]         incorrect_q;
  logic [2:0]         round_q;
  logic [6:0]         timer_q;
  logic               correct_q;

  logic               confirm_edge;
  logic               tick;
  logic               level_changed;
  logic               locked;
  logic [6:0]         load_value;
  logic               do_load;
  logic               run;
  logic               accept;

  assign confirm_edge  = bus.confirmButton & ~confirm_prev;
  assign tick          = (prescaler == PRESC_LAST);
  assign level_changed = (bus.Max_digit != level_reg);
  assign locked        = (bus.Max_incorrect_guesses != 3'd0) &&
                         (incorrect_q >= bus.Max_incorrect_guesses);
  assign load_value    = SECONDS * {5'd0, bus.Max_digit};

  // Next-state and datapath control; a level change wins over any guess in that cycle
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    run        = 1'b0;
    accept     = 1'b0;
    case (state)
      LOAD: begin
        do_load    = 1'b1;
        state_next = (bus.Max_digit != 2'd0) ? PLAY : HOLD;
      end
      PLAY: begin
        if (level_changed) begin
          state_next = LOAD;
        end else begin
          run    = 1'b1;
          accept = confirm_edge && (timer_q != 7'd0) && !locked;
          if (timer_q == 7'd0) state_next = HOLD;
        end
      end
      HOLD: begin
        if (level_changed) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge restart) begin
    if (restart) state <= LOAD;
    else         state <= state_next;
  end

  // Counters, timer, prescaler and the confirm edge detector
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      level_reg    <= 2'd0;
      prescaler    <= '0;
      confirm_prev <= 1'b0;
      incorrect_q  <= 3'd0;
      round_q      <= 3'd0;
      timer_q      <= 7'd0;
      correct_q    <= 1'b0;
    end else begin
      confirm_prev <= bus.confirmButton;
      correct_q    <= 1'b0;
      if (do_load) begin
        round_q     <= 3'd0;
        incorrect_q <= 3'd0;
        timer_q     <= load_value;
        prescaler   <= '0;
        level_reg   <= bus.Max_digit;
      end else if (run) begin
        prescaler <= tick ? '0 : prescaler + PRESC_W'(1);
        if (tick && (timer_q != 7'd0)) timer_q <= timer_q - 7'd1;
        if (accept) begin
          if (bus.guess == bus.target) begin
            if (round_q != 3'd7) round_q <= round_q + 3'd1;
            correct_q <= 1'b1;
          end else if (incorrect_q != 3'd7) begin
            incorrect_q <= incorrect_q + 3'd1;
          end
        end
      end
    end
  end

  assign bus.incorrect_guesses = incorrect_q;
  assign bus.round             = round_q;
  assign bus.timer             = timer_q;
  assign bus.correct           = correct_q;
  assign bus.new_target        = correct_q;
  assign bus.locked_out        = locked;

endmodule

// File: tb/tb_round_tracker.sv
// Testbench for round_tracker with a fast prescaler (10 cycles per second):
// a vector table of guesses, hand-written timing sequences, and a randomized
// run compared against a seconds-and-counts reference model.
module tb_round_tracker;
  localparam int CLK_HZ        = 10;
  localparam int ROUND_SECONDS = 30;

  logic clk = 1'b0;
  logic restart;

  round_tracker_if bus ();

  round_tracker #(.CLK_HZ(CLK_HZ), .ROUND_SECONDS(ROUND_SECONDS)) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit         press;
    logic [9:0] guess;
    logic [9:0] target;
    logic [2:0] maxInc;
    int         expRound;
    int         expWrong;
    bit         expCorrect;
    bit         expLocked;
  } vec_t;

  vec_t vecs[11];

  // Reference model state: level bookkeeping in seconds and plain counts
  bit mPendingLoad;
  int mLevel, mRound, mWrong, mElapsed, mLoadVal;
  bit mCorrect, mPrev;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic btn, input logic [9:0] g, input logic [9:0] t,
                               input logic [1:0] md, input logic [2:0] mi);
    bus.confirmButton         = btn;
    bus.guess                 = g;
    bus.target                = t;
    bus.Max_digit             = md;
    bus.Max_incorrect_guesses = mi;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int modelTimer();
    int v;
    v = mLoadVal - mElapsed / CLK_HZ;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic modelReset();
    mPendingLoad = 1'b1;
    mLevel = 0; mRound = 0; mWrong = 0; mElapsed = 0; mLoadVal = 0;
    mCorrect = 1'b0; mPrev = 1'b0;
  endtask

  task automatic modelStep();
    int  secondsLeft;
    bit  pressed, lockNow;
    secondsLeft = modelTimer();
    pressed     = bus.confirmButton && !mPrev;
    lockNow     = (bus.Max_incorrect_guesses != 0) && (mWrong >= int'(bus.Max_incorrect_guesses));
    mCorrect    = 1'b0;
    if (mPendingLoad) begin
      mPendingLoad = 1'b0;
      mLevel   = int'(bus.Max_digit);
      mLoadVal = ROUND_SECONDS * int'(bus.Max_digit);
      mElapsed = 0; mRound = 0; mWrong = 0;
    end else if (int'(bus.Max_digit) != mLevel) begin
      mPendingLoad = 1'b1;
    end else if (secondsLeft > 0) begin
      mElapsed++;
      if (pressed && !lockNow) begin
        if (bus.guess == bus.target) begin
          if (mRound < 7) mRound++;
          mCorrect = 1'b1;
        end else if (mWrong < 7) begin
          mWrong++;
        end
      end
    end
    mPrev = bus.confirmButton;
  endtask

  initial begin
    int n;
    logic btn;
    vecs[0]  = '{1'b1, 10'd42,  10'd42,  3'd3, 1, 0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 10'd41,  10'd42,  3'd3, 1, 1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 10'd999, 10'd998, 3'd3, 1, 2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 10'd0,   10'd0,   3'd3, 2, 2, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 10'd554, 10'd42,  3'd3, 2, 3, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 10'd7,   10'd7,   3'd3, 2, 3, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 10'd7,   10'd7,   3'd4, 3, 3, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 10'd1,   10'd2,   3'd4, 3, 4, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 10'd1,   10'd2,   3'd0, 3, 4, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 10'd1,   10'd2,   3'd5, 3, 4, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 10'd1,   10'd2,   3'd4, 3, 4, 1'b0, 1'b1};

    restart = 1'b1;
    applyStimulus(1'b0, 10'd0, 10'd0, 2'd1, 3'd0);
    waitCycles(2);
    checkOutput("reset round", bus.round, 0);
    checkOutput("reset wrong", bus.incorrect_guesses, 0);
    checkOutput("reset timer", bus.timer, 0);
    checkOutput("reset correct", bus.correct, 0);
    checkOutput("reset new_target", bus.new_target, 0);
    checkOutput("reset locked", bus.locked_out, 0);

    $display("[TB] timer load, first tick and tick coincident with a guess");
    applyStimulus(1'b0, 10'd5, 10'd5, 2'd1, 3'd3);
    restart = 1'b0;
    waitCycles(2);
    checkOutput("load timer", bus.timer, 30);
    waitCycles(8);
    checkOutput("pre-tick timer", bus.timer, 30);
    applyStimulus(1'b1, 10'd5, 10'd5, 2'd1, 3'd3);
    waitCycles(1);
    checkOutput("tick timer", bus.timer, 29);
    checkOutput("tick round", bus.round, 1);
    checkOutput("tick correct", bus.correct, 1);
    checkOutput("tick new_target", bus.new_target, 1);
    applyStimulus(1'b0, 10'd5, 10'd5, 2'd1, 3'd3);
    waitCycles(1);
    checkOutput("post-tick timer", bus.timer, 29);
    checkOutput("pulse end correct", bus.correct, 0);

    $display("[TB] guess table at level 2");
    applyStimulus(1'b0, 10'd0, 10'd0, 2'd2, 3'd3);
    waitCycles(3);
    checkOutput("level2 timer", bus.timer, 60);
    checkOutput("level2 round", bus.round, 0);
    checkOutput("level2 wrong", bus.incorrect_guesses, 0);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].press, vecs[i].guess, vecs[i].target, 2'd2, vecs[i].maxInc);
      waitCycles(1);
      checkOutput($sformatf("vec%0d round", i), bus.round, vecs[i].expRound);
      checkOutput($sformatf("vec%0d wrong", i), bus.incorrect_guesses, vecs[i].expWrong);
      checkOutput($sformatf("vec%0d correct", i), bus.correct, int'(vecs[i].expCorrect));
      checkOutput($sformatf("vec%0d new_target", i), bus.new_target, int'(vecs[i].expCorrect));
      checkOutput($sformatf("vec%0d locked", i), bus.locked_out, int'(vecs[i].expLocked));
      applyStimulus(1'b0, vecs[i].guess, vecs[i].target, 2'd2, vecs[i].maxInc);
      waitCycles(1);
      checkOutput($sformatf("vec%0d pulse end", i), bus.correct, 0);
    end

    $display("[TB] button held across a level reload");
    applyStimulus(1'b1, 10'd3, 10'd3, 2'd1, 3'd0);
    waitCycles(4);
    checkOutput("held round", bus.round, 0);
    checkOutput("held wrong", bus.incorrect_guesses, 0);
    checkOutput("held timer", bus.timer, 30);
    checkOutput("held correct", bus.correct, 0);

    $display("[TB] level change racing a confirm");
    applyStimulus(1'b0, 10'd9, 10'd9, 2'd1, 3'd0);
    waitCycles(1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 10'd9, 10'd9, 2'd1, 3'd0);
      waitCycles(1);
      applyStimulus(1'b0, 10'd9, 10'd9, 2'd1, 3'd0);
      waitCycles(1);
    end
    checkOutput("five rounds", bus.round, 5);
    applyStimulus(1'b1, 10'd9, 10'd9, 2'd2, 3'd0);
    waitCycles(1);
    checkOutput("dropped round", bus.round, 5);
    checkOutput("dropped correct", bus.correct, 0);
    waitCycles(1);
    checkOutput("reload round", bus.round, 0);
    checkOutput("reload wrong", bus.incorrect_guesses, 0);
    checkOutput("reload timer", bus.timer, 60);
    applyStimulus(1'b0, 10'd9, 10'd9, 2'd2, 3'd0);

    $display("[TB] timer expiry at level 1");
    applyStimulus(1'b0, 10'd9, 10'd9, 2'd1, 3'd0);
    waitCycles(2);
    checkOutput("expiry start timer", bus.timer, 30);
    n = 0;
    while (bus.timer != 7'd0 && n < 400) begin
      waitCycles(1);
      n++;
    end
    checkOutput("expiry cycles", n, 300);
    waitCycles(5);
    checkOutput("expired timer", bus.timer, 0);
    applyStimulus(1'b1, 10'd9, 10'd9, 2'd1, 3'd0);
    waitCycles(1);
    checkOutput("expired correct", bus.correct, 0);
    checkOutput("expired round", bus.round, 0);
    applyStimulus(1'b0, 10'd9, 10'd9, 2'd1, 3'd0);
    waitCycles(1);
    checkOutput("expired timer hold", bus.timer, 0);

    $display("[TB] asynchronous restart mid-round");
    applyStimulus(1'b0, 10'd1, 10'd1, 2'd3, 3'd0);
    waitCycles(2);
    checkOutput("level3 timer", bus.timer, 90);
    applyStimulus(1'b1, 10'd1, 10'd1, 2'd3, 3'd0);
    @(posedge clk);
    #2 restart = 1'b1;
    #1;
    checkOutput("async round", bus.round, 0);
    checkOutput("async wrong", bus.incorrect_guesses, 0);
    checkOutput("async timer", bus.timer, 0);
    checkOutput("async correct", bus.correct, 0);
    checkOutput("async new_target", bus.new_target, 0);

    $display("[TB] randomized run against reference model");
    modelReset();
    btn = 1'b0;
    applyStimulus(1'b0, 10'd0, 10'd0, 2'd1, 3'd3);
    waitCycles(1);
    restart = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      logic [9:0] t;
      logic [9:0] g;
      logic [1:0] md;
      logic [2:0] mi;
      t  = bus.target;
      md = bus.Max_digit;
      mi = bus.Max_incorrect_guesses;
      if ($urandom_range(0, 2) == 0) btn = ~btn;
      if ($urandom_range(0, 19) == 0) t = 10'($urandom_range(0, 999));
      g = ($urandom_range(0, 1) == 1) ? t : 10'($urandom_range(0, 999));
      if ($urandom_range(0, 59) == 0) mi = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) md = 2'($urandom_range(0, 3));
      restart = ($urandom_range(0, 999) == 0);
      applyStimulus(btn, g, t, md, mi);
      @(posedge clk);
      if (restart) modelReset();
      else         modelStep();
      @(negedge clk);
      checkOutput($sformatf("rnd%0d round", cyc), bus.round, mRound);
      checkOutput($sformatf("rnd%0d wrong", cyc), bus.incorrect_guesses, mWrong);
      checkOutput($sformatf("rnd%0d timer", cyc), bus.timer, modelTimer());
      checkOutput($sformatf("rnd%0d correct", cyc), bus.correct, int'(mCorrect));
      checkOutput($sformatf("rnd%0d new_target", cyc), bus.new_target, int'(mCorrect));
      checkOutput($sformatf("rnd%0d locked", cyc), bus.locked_out,
                  int'((bus.Max_incorrect_guesses != 0) && (mWrong >= int'(bus.Max_incorrect_guesses))));
    end
    restart = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
